// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the shift-add-3 digit constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL    = 3;

endpackage

// File: rtl/bcd_add3_digit.sv
// Single BCD digit correction for double-dabble: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    // 4-bit correction; never carries out of the digit for valid BCD input
    always_comb begin
        d_out = (d_in >= DIGIT_W'(ADD3_THRESH)) ? d_in + DIGIT_W'(ADD3_VAL) : d_in;
    end

endmodule

// File: rtl/bin2bcd_seq10.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per cycle.
// start/busy/done handshake: start is sampled only in IDLE; busy is high for
// the WIDTH shift cycles; done pulses one cycle when bcd_out is updated.
// bcd_out holds the previous result until the next conversion completes.
// Optional macro BIN2BCD_BLANK_EN adds a registered leading-zero blank mask.
module bin2bcd_seq10
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_out
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    corr;
    logic [DIGITS-1:0]   blank_next;
    logic [DIGITS-1:0]   blank_q, blank_d;

    // Per-digit add-3 correction of the current scratch value
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .d_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_out (corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Top corrected bit shifts out; it is always zero for legal parameters
    logic unused_corr_msb;
    assign unused_corr_msb = corr[BCD_W-1];

`ifdef BIN2BCD_BLANK_EN
    // Blank digit i when it and every higher digit are zero; digit 0 always shown
    always_comb begin
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero       = hi_zero && (scratch_q[i*DIGIT_W +: DIGIT_W] == '0);
            blank_next[i] = (i != 0) ? hi_zero : 1'b0;
        end
    end
    assign blank_out = blank_q;
`else
    // No blanking: mask stays zero and is not exported
    always_comb begin
        blank_next = '0;
    end
`endif

    // Next-state logic for the FSM, datapath and registered outputs
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    count_d   = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shift_d} = {corr[BCD_W-2:0], shift_q, 1'b0};
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                blank_d = blank_next;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq10.sv
// Bench for bin2bcd_seq10: vector table, randomized values against a decimal
// reference model, and hand-written sequences for ignored start, reset abort
// and back-to-back conversions. Define BIN2BCD_BLANK_EN to cover blank_out.
module tb_bin2bcd_seq10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank_out;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  exp_blank_q[$];

    bin2bcd_seq10 #(.WIDTH(10), .DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank_out (blank_out)
`endif
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int d;
        r = '0;
        d = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    // Reference: digit i (i>=1) blank when the value has at most i decimal digits
    function automatic logic [3:0] model_blank(input int v);
        logic [3:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    // Assert start for one cycle from a negedge; returns at the next negedge (cycle 0)
    task automatic launch(input logic [9:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 10'($urandom_range(0, 1023));
    endtask

    // Wait (bounded) for done; count cycles, busy cycles and bcd_out changes
    task automatic wait_done(input int lat0, input logic [15:0] hold,
                             output int lat, output int busy_n, output int hold_err,
                             output bit seen);
        lat = lat0; busy_n = 0; hold_err = 0; seen = 1'b0;
        while (lat < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (bcd_out !== hold) hold_err++;
            @(negedge clk);
            lat++;
        end
    endtask

    // One full conversion with scoreboard; ends at negedge of the cycle after done
    task automatic run_one(input logic [9:0] v, input string tag);
        int lat, busy_n, hold_err;
        bit seen;
        logic [15:0] e;
        logic [3:0] eb;
        exp_q.push_back(model_bcd(int'(v)));
        exp_blank_q.push_back(model_blank(int'(v)));
        launch(v);
        wait_done(0, bcd_out, lat, busy_n, hold_err, seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
        check({tag, "_bcd_hold"}, 32'(hold_err), 32'd0);
        e  = exp_q.pop_front();
        eb = exp_blank_q.pop_front();
        check({tag, "_bcd"}, 32'(bcd_out), 32'(e));
`ifdef BIN2BCD_BLANK_EN
        check({tag, "_blank"}, 32'(blank_out), 32'(eb));
`else
        if (eb === 4'hx) $display("unexpected blank model value");
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, busy_n, hold_err, n_done;
        bit seen;
        logic [15:0] prev;

        vecs[0] = '{10'd0,    16'h0000, 4'b1110};
        vecs[1] = '{10'd1023, 16'h1023, 4'b0000};
        vecs[2] = '{10'd599,  16'h0599, 4'b1000};
        vecs[3] = '{10'd10,   16'h0010, 4'b1100};
        vecs[4] = '{10'd42,   16'h0042, 4'b1100};
        vecs[5] = '{10'd1000, 16'h1000, 4'b0000};
        vecs[6] = '{10'd999,  16'h0999, 4'b1000};
        vecs[7] = '{10'd305,  16'h0305, 4'b1000};
        vecs[8] = '{10'd9,    16'h0009, 4'b1110};

        // reset
        rst = 1'b1; start = 1'b0; bin_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank", 32'(blank_out), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // table vectors: fixed expectations
        for (int i = 0; i < 9; i++) begin
            int lat_t, busy_t, hold_t;
            bit seen_t;
            launch(vecs[i].bin);
            wait_done(0, bcd_out, lat_t, busy_t, hold_t, seen_t);
            check("vec_latency", 32'(lat_t), 32'd11);
            check("vec_busy_cycles", 32'(busy_t), 32'd10);
            check("vec_bcd", 32'(bcd_out), 32'(vecs[i].bcd));
`ifdef BIN2BCD_BLANK_EN
            check("vec_blank", 32'(blank_out), 32'(vecs[i].blank));
`endif
            @(negedge clk);
        end

        // randomized, back-to-back against the reference model
        for (int i = 0; i < 30; i++) begin
            run_one(10'($urandom_range(0, 1023)), "rand");
        end

        // start while busy is ignored
        launch(10'd42);
        repeat (3) @(negedge clk);
        start = 1'b1; bin_in = 10'd999;
        @(negedge clk);
        start = 1'b0;
        prev = bcd_out;
        wait_done(4, prev, lat, busy_n, hold_err, seen);
        check("ign_latency", 32'(lat), 32'd11);
        check("ign_bcd", 32'(bcd_out), 32'h0042);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ign_extra_done", 32'(n_done), 32'd0);
        check("ign_bcd_after", 32'(bcd_out), 32'h0042);

        // reset mid-conversion
        launch(10'd777);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // back-to-back: start in the cycle after done
        run_one(10'd123, "b2b_first");
        run_one(10'd305, "b2b_second");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
